// File: rtl/pcs_deskew_if.sv
// Lane bus between the PCS lock stage and the deskew block.
// Optional macro DESKEW_DONE_EN adds the o_deskew_done status line.
interface pcs_deskew_if #(
  parameter int unsigned N_LANES  = 20,
  parameter int unsigned NB_DATA  = 66,
  parameter int unsigned NB_COUNT = 5
);
  logic                          i_enable;
  logic                          i_valid;
  logic [N_LANES-1:0]            i_resync;
  logic [N_LANES-1:0]            i_start_of_lane;
  logic [N_LANES*NB_DATA-1:0]    i_data;
  logic                          o_set_fifo_delay;
  logic [N_LANES*NB_COUNT-1:0]   o_lane_delay;
  logic [N_LANES*NB_DATA-1:0]    o_data;
`ifdef DESKEW_DONE_EN
  logic                          o_deskew_done;
`endif

  // Source side: drives lane data and control, observes deskew results.
  modport master (
    output i_enable, i_valid, i_resync, i_start_of_lane, i_data,
`ifdef DESKEW_DONE_EN
    input  o_deskew_done,
`endif
    input  o_set_fifo_delay, o_lane_delay, o_data
  );

  // Deskew block side.
  modport slave (
    input  i_enable, i_valid, i_resync, i_start_of_lane, i_data,
`ifdef DESKEW_DONE_EN
    output o_deskew_done,
`endif
    output o_set_fifo_delay, o_lane_delay, o_data
  );
endinterface

// File: rtl/pcs_deskew_top.sv
// 100GbE PCS receive multi-lane deskew: measures alignment-marker skew across
// lanes and delays each lane so all lanes leave aligned.
// Optional macro DESKEW_DONE_EN adds the sticky o_deskew_done status output.
module pcs_deskew_top #(
  parameter int unsigned N_LANES    = 20,
  parameter int unsigned NB_DATA    = 66,
  parameter int unsigned FIFO_DEPTH = 20,
  parameter int unsigned MAX_SKEW   = 16,
  parameter int unsigned NB_COUNT   = $clog2(FIFO_DEPTH)
) (
  input  logic         i_clock,
  input  logic         i_reset,
  pcs_deskew_if.slave  bus
);

  // Skew counter leaves headroom above MAX_SKEW so it never wraps.
  localparam int unsigned NB_CNT = $clog2(MAX_SKEW + 2);
  // Tap 0 is the live input, so only FIFO_DEPTH-1 storage stages are needed.
  localparam int unsigned N_TAPS = FIFO_DEPTH - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  logic                        adv_c;
  logic                        load_c;
  logic [N_LANES-1:0]          new_c;
  state_t                      state_q, state_d;
  logic [NB_CNT-1:0]           cnt_q, cnt_d;
  logic [N_LANES-1:0]          seen_q, seen_d;
  logic [NB_COUNT-1:0]         arr_q [N_LANES];
  logic [NB_COUNT-1:0]         arr_d [N_LANES];
  logic [N_LANES*NB_COUNT-1:0] delay_q, delay_d;
  logic                        set_q;
`ifdef DESKEW_DONE_EN
  logic                        done_q, done_d;
`endif

  logic [NB_DATA-1:0]          lane_in_c [N_LANES];
  logic [NB_DATA-1:0]          tap_c     [N_LANES];
  logic [NB_DATA-1:0]          line_q    [N_LANES][N_TAPS];
  logic [N_LANES*NB_DATA-1:0]  data_q;

  assign adv_c = bus.i_enable & bus.i_valid;
  assign new_c = bus.i_start_of_lane & ~seen_q;

  // Skew measurement FSM: next state, arrival capture and delay computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    arr_d   = arr_q;
    delay_d = delay_q;
    load_c  = 1'b0;
`ifdef DESKEW_DONE_EN
    done_d  = done_q;
`endif
    if (adv_c) begin
      if (|bus.i_resync) begin
        // Resync wins over any marker flags seen in the same block.
        state_d = ST_IDLE;
        cnt_d   = '0;
        seen_d  = '0;
`ifdef DESKEW_DONE_EN
        done_d  = 1'b0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (|bus.i_start_of_lane) begin
              cnt_d  = NB_CNT'(1);
              seen_d = bus.i_start_of_lane;
              for (int i = 0; i < int'(N_LANES); i++) begin
                if (bus.i_start_of_lane[i]) arr_d[i] = '0;
              end
              if (&bus.i_start_of_lane) begin
                state_d = ST_DONE;
                delay_d = '0;
                load_c  = 1'b1;
              end else begin
                state_d = ST_COUNT;
              end
            end
          end
          ST_COUNT: begin
            seen_d = seen_q | bus.i_start_of_lane;
            for (int i = 0; i < int'(N_LANES); i++) begin
              if (new_c[i]) arr_d[i] = NB_COUNT'(cnt_q);
            end
            cnt_d = cnt_q + NB_CNT'(1);
            if (&seen_d) begin
              // Latest lane gets delay 0, earliest the largest delay.
              state_d = ST_DONE;
              load_c  = 1'b1;
              for (int i = 0; i < int'(N_LANES); i++) begin
                delay_d[(N_LANES-1-i)*NB_COUNT +: NB_COUNT] =
                  NB_COUNT'(cnt_q) - arr_d[i];
              end
            end else if (cnt_q == NB_CNT'(MAX_SKEW)) begin
              // Skew too large: abandon this measurement, keep old delays.
              state_d = ST_IDLE;
              cnt_d   = '0;
              seen_d  = '0;
            end
          end
          ST_DONE: begin
            state_d = ST_DONE;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
`ifdef DESKEW_DONE_EN
      if (load_c) done_d = 1'b1;
`endif
    end
  end

  // FSM and measurement state registers; the load pulse lasts one cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      seen_q  <= '0;
      arr_q   <= '{default: '0};
      delay_q <= '0;
      set_q   <= 1'b0;
`ifdef DESKEW_DONE_EN
      done_q  <= 1'b0;
`endif
    end else begin
      set_q <= load_c;
      if (adv_c) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        seen_q  <= seen_d;
        arr_q   <= arr_d;
        delay_q <= delay_d;
`ifdef DESKEW_DONE_EN
        done_q  <= done_d;
`endif
      end
    end
  end

  // Per-lane tap select: delay d picks the block that arrived d cycles ago.
  always_comb begin
    for (int l = 0; l < int'(N_LANES); l++) begin
      lane_in_c[l] = bus.i_data[(N_LANES-1-l)*NB_DATA +: NB_DATA];
      tap_c[l]     = lane_in_c[l];
      for (int k = 1; k <= int'(N_TAPS); k++) begin
        if (delay_q[(N_LANES-1-l)*NB_COUNT +: NB_COUNT] == NB_COUNT'(k)) begin
          tap_c[l] = line_q[l][k-1];
        end
      end
    end
  end

  // Delay lines and output register; no flush when the delays change.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int l = 0; l < int'(N_LANES); l++) begin
        for (int k = 0; k < int'(N_TAPS); k++) begin
          line_q[l][k] <= '0;
        end
      end
      data_q <= '0;
    end else if (adv_c) begin
      for (int l = 0; l < int'(N_LANES); l++) begin
        line_q[l][0] <= lane_in_c[l];
        for (int k = 1; k < int'(N_TAPS); k++) begin
          line_q[l][k] <= line_q[l][k-1];
        end
        data_q[(N_LANES-1-l)*NB_DATA +: NB_DATA] <= tap_c[l];
      end
    end
  end

  assign bus.o_set_fifo_delay = set_q;
  assign bus.o_lane_delay     = delay_q;
  assign bus.o_data           = data_q;
`ifdef DESKEW_DONE_EN
  assign bus.o_deskew_done    = done_q;
`endif

endmodule

// File: tb/tb_pcs_deskew_top.sv
// Directed bench for pcs_deskew_top: dut_a uses MAX_SKEW=19, dut_b the default 16.
module tb_pcs_deskew_top;
  localparam int unsigned NL = 20;
  localparam int unsigned ND = 66;
  localparam int unsigned NC = 5;
  localparam int unsigned W  = NL * ND;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable, valid;
  logic [NL-1:0]  resync, sol;
  logic [W-1:0]   data;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]       hist [$];
  logic [W-1:0]       exp_o;
  logic [NL*NC-1:0]   dly_now;

  pcs_deskew_if #(.N_LANES(NL), .NB_DATA(ND), .NB_COUNT(NC)) ifa ();
  pcs_deskew_if #(.N_LANES(NL), .NB_DATA(ND), .NB_COUNT(NC)) ifb ();

  assign ifa.i_enable = enable;  assign ifb.i_enable = enable;
  assign ifa.i_valid  = valid;   assign ifb.i_valid  = valid;
  assign ifa.i_resync = resync;  assign ifb.i_resync = resync;
  assign ifa.i_start_of_lane = sol;  assign ifb.i_start_of_lane = sol;
  assign ifa.i_data   = data;    assign ifb.i_data   = data;

  pcs_deskew_top #(.MAX_SKEW(19)) dut_a (.i_clock(clk), .i_reset(rst), .bus(ifa));
  pcs_deskew_top                  dut_b (.i_clock(clk), .i_reset(rst), .bus(ifb));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          v;
    logic [NL-1:0] rs;
    logic [NL-1:0] sl;
    logic          eset;
    logic [NL*NC-1:0] edly;
    logic          edone;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [NL*NC-1:0] mk_dly(input int base, input int lane, input int lv);
    logic [NL*NC-1:0] r;
    for (int i = 0; i < 20; i++) r[(19-i)*5 +: 5] = (i == lane) ? 5'(lv) : 5'(base);
    return r;
  endfunction

  function automatic logic [NL*NC-1:0] mk_stag();
    logic [NL*NC-1:0] r;
    for (int i = 0; i < 20; i++) r[(19-i)*5 +: 5] = 5'(19 - i);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r = '0;
    for (int w = 0; w < 42; w++) r = (r << 32) | W'($urandom);
    return r;
  endfunction

  // Expected output: lane l shows the block that entered d_l advancing cycles ago.
  function automatic logic [W-1:0] model_out(input logic [NL*NC-1:0] dl);
    logic [W-1:0] r;
    int n = hist.size();
    for (int l = 0; l < 20; l++) begin
      int d = int'(dl[(19-l)*5 +: 5]);
      logic [W-1:0] h = hist[n-1-d];
      r[(19-l)*66 +: 66] = h[(19-l)*66 +: 66];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, act, expv);
    end
  endtask

  task automatic chk_data(input string nm, input int idx, input logic [W-1:0] act, input logic [W-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      for (int l = 0; l < 20; l++) begin
        if (act[(19-l)*66 +: 66] !== expv[(19-l)*66 +: 66]) begin
          $display("FAIL %s[%0d] lane %0d: got %0h want %0h", nm, idx, l,
                   act[(19-l)*66 +: 66], expv[(19-l)*66 +: 66]);
          break;
        end
      end
    end
  endtask

  // Apply one cycle of stimulus, update the reference model, sample after the edge.
  task automatic step(input logic v, input logic [NL-1:0] rs, input logic [NL-1:0] sl, input logic [W-1:0] dat);
    valid = v; resync = rs; sol = sl; data = dat;
    if (rst) exp_o = '0;
    else if (enable && v) begin
      hist.push_back(dat);
      exp_o = model_out(dly_now);
    end
    @(posedge clk);
    #1;
  endtask

  logic [NL*NC-1:0] z, d2, dst, d17, d16;
  logic [65:0]      mark;
  logic [W-1:0]     mdat;

  initial begin
    z   = '0;
    d2  = mk_dly(2, 3, 0);
    dst = mk_stag();
    d17 = mk_dly(17, 19, 0);
    d16 = mk_dly(16, 19, 0);
    mark = 66'h2_DEAD_BEEF_CAFE_F00D;

    tbl[0]  = '{1'b1, 20'h00000, 20'hFFFFF, 1'b1, z,  1'b1};
    tbl[1]  = '{1'b1, 20'h00000, 20'h00000, 1'b0, z,  1'b1};
    tbl[2]  = '{1'b1, 20'h00020, 20'hFFFFF, 1'b0, z,  1'b0};
    tbl[3]  = '{1'b1, 20'h00000, 20'h00000, 1'b0, z,  1'b0};
    tbl[4]  = '{1'b1, 20'h00000, 20'hFFFF7, 1'b0, z,  1'b0};
    tbl[5]  = '{1'b1, 20'h00000, 20'h00001, 1'b0, z,  1'b0};
    tbl[6]  = '{1'b1, 20'h00000, 20'h00008, 1'b1, d2, 1'b1};
    tbl[7]  = '{1'b1, 20'h00000, 20'h00000, 1'b0, d2, 1'b1};
    tbl[8]  = '{1'b1, 20'h00001, 20'h00000, 1'b0, d2, 1'b0};
    tbl[9]  = '{1'b1, 20'h00000, 20'hFFFF7, 1'b0, d2, 1'b0};
    tbl[10] = '{1'b0, 20'h00000, 20'h00000, 1'b0, d2, 1'b0};
    tbl[11] = '{1'b0, 20'h00000, 20'h00008, 1'b0, d2, 1'b0};
    tbl[12] = '{1'b0, 20'h00000, 20'h00000, 1'b0, d2, 1'b0};
    tbl[13] = '{1'b1, 20'h00000, 20'h00000, 1'b0, d2, 1'b0};
    tbl[14] = '{1'b1, 20'h00000, 20'h00008, 1'b1, d2, 1'b1};
    tbl[15] = '{1'b1, 20'h00000, 20'h00000, 1'b0, d2, 1'b1};

    rst = 1'b1; enable = 1'b1; valid = 1'b1; resync = '0; sol = '0; data = '0;
    for (int i = 0; i < 19; i++) hist.push_back('0);
    dly_now = '0;
    exp_o   = '0;

    // Reset held for two cycles with random data.
    for (int r = 0; r < 2; r++) begin
      step(1'b1, '0, '0, rnd());
      chk_data("rst_data", r, ifa.o_data, '0);
      chk("rst_dly", r, 128'(ifa.o_lane_delay), 128'(0));
      chk("rst_set", r, 128'(ifa.o_set_fifo_delay), 128'(0));
`ifdef DESKEW_DONE_EN
      chk("rst_done", r, 128'(ifa.o_deskew_done), 128'(0));
`endif
    end
    rst = 1'b0;

    // Zero delay: one cycle pass-through.
    for (int p = 0; p < 3; p++) begin
      step(1'b1, '0, '0, rnd());
      chk_data("pass", p, ifa.o_data, exp_o);
      chk("pass_set", p, 128'(ifa.o_set_fifo_delay), 128'(0));
    end

    // Enable low freezes everything, including marker capture.
    enable = 1'b0;
    step(1'b1, '0, 20'hFFFFF, rnd());
    chk_data("en_hold", 0, ifa.o_data, exp_o);
    chk("en_set", 0, 128'(ifa.o_set_fifo_delay), 128'(0));
    enable = 1'b1;

    // Table: all-lanes, resync priority, lane 3 late, valid gap.
    for (int r = 0; r < 16; r++) begin
      step(tbl[r].v, tbl[r].rs, tbl[r].sl, rnd());
      chk("tbl_set", r, 128'(ifa.o_set_fifo_delay), 128'(tbl[r].eset));
      chk("tbl_dly", r, 128'(ifa.o_lane_delay), 128'(tbl[r].edly));
      chk_data("tbl_data", r, ifa.o_data, exp_o);
`ifdef DESKEW_DONE_EN
      chk("tbl_done", r, 128'(ifa.o_deskew_done), 128'(tbl[r].edone));
`endif
      dly_now = tbl[r].edly;
    end

    // Staggered arrival: lane i flagged at cycle i, full 19-cycle skew.
    step(1'b1, 20'h00001, '0, rnd());
    chk("stag_rsync_set", 0, 128'(ifa.o_set_fifo_delay), 128'(0));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, '0, NL'(1) << i, rnd());
      chk("stag_set", i, 128'(ifa.o_set_fifo_delay), 128'(i == 19));
      chk_data("stag_data", i, ifa.o_data, exp_o);
    end
    chk("stag_dly", 0, 128'(ifa.o_lane_delay), 128'(dst));
    dly_now = dst;

    // Markers injected on lane l at cycle l+4 must come out on all lanes together.
    for (int c = 0; c < 24; c++) begin
      mdat = '0;
      for (int l = 0; l < 20; l++) if (c == l + 4) mdat[(19-l)*66 +: 66] = mark;
      step(1'b1, '0, '0, mdat);
      chk_data("mark_data", c, ifa.o_data, exp_o);
      if (c == 22) begin
        int hits = 0;
        for (int l = 0; l < 20; l++) if (ifa.o_data[(19-l)*66 +: 66] == mark) hits++;
        chk("mark_early", c, 128'(hits), 128'(0));
      end
      if (c == 23) chk_data("mark_align", c, ifa.o_data, {20{mark}});
    end

    // Timeout on dut_b at counter 16; lane 19 at cycle 17 must only restart it.
    step(1'b1, 20'h00001, '0, rnd());
    chk("to_rsync_set", 0, 128'(ifb.o_set_fifo_delay), 128'(0));
    for (int k = 0; k <= 17; k++) begin
      step(1'b1, '0, (k == 0) ? 20'h7FFFF : ((k == 17) ? 20'h80000 : 20'h00000), rnd());
      chk("to_b_set", k, 128'(ifb.o_set_fifo_delay), 128'(0));
      chk("to_a_set", k, 128'(ifa.o_set_fifo_delay), 128'(k == 17));
      chk_data("to_data", k, ifa.o_data, exp_o);
    end
    chk("to_b_dly", 0, 128'(ifb.o_lane_delay), 128'(d2));
    chk("to_a_dly", 0, 128'(ifa.o_lane_delay), 128'(d17));
    dly_now = d17;

    // Last lane arriving exactly at counter MAX_SKEW is still accepted.
    step(1'b1, 20'h00001, '0, rnd());
    for (int k = 0; k <= 16; k++) begin
      step(1'b1, '0, (k == 0) ? 20'h7FFFF : ((k == 16) ? 20'h80000 : 20'h00000), rnd());
      chk("edge_b_set", k, 128'(ifb.o_set_fifo_delay), 128'(k == 16));
      chk_data("edge_data", k, ifa.o_data, exp_o);
    end
    chk("edge_b_dly", 0, 128'(ifb.o_lane_delay), 128'(d16));
    chk("edge_a_dly", 0, 128'(ifa.o_lane_delay), 128'(d16));
    dly_now = d16;
    step(1'b1, '0, '0, rnd());
    chk("edge_b_once", 0, 128'(ifb.o_set_fifo_delay), 128'(0));
    chk_data("edge_tail", 0, ifa.o_data, exp_o);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
